arb_mux_n: RTL and testbench
============================

# arb_mux_n

Parametrised, registered N-channel multiplexer with valid/ready handshakes on every input and on the output. It generalises the combinational 16-bit 4-way and 8-way muxes to arbitrary width and channel count. It adds a one-deep output register and two grant modes: explicit select and round-robin. It sits between multiple data producers (register-file read ports, memory-mapped sources) and a single consumer on the datapath bus.

## Interface
Parameters:
- WIDTH, 16, data width per channel (≥1)
- CHANNELS, 8, number of input channels (≥2, need not be a power of 2)
- SEL_W, derived as ceil(log2(CHANNELS)); local, not overridable

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel data valid
- in_ready  output  CHANNELS  per-channel accept; at most one bit high per cycle
- sel  input  SEL_W  channel select, used when rr_en=0
- rr_en  input  1  1 = round-robin grant, 0 = fixed grant by sel
- out_data  output  WIDTH  registered output data
- out_chan  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  output register holds data
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Reset values: out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=0. While rst_n=0, all in_ready bits are 0.
- load_en = !out_valid || out_ready. The output register accepts new data when it is empty or being drained in the same cycle.
- Grant with rr_en=0: grant=sel when sel<CHANNELS and in_valid[sel]=1. Otherwise there is no grant. Values of sel ≥ CHANNELS never grant.
- Grant with rr_en=1: grant is the first i with in_valid[i]=1, scanning ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1. No valid channel means no grant.
- in_ready[grant] = load_en, evaluated combinationally from out_ready and out_valid. All other in_ready bits are 0.
- Transfer on channel g when in_valid[g] && in_ready[g]. At the next edge: out_data←in_data[g], out_chan←g, out_valid←1.
- When out_valid && out_ready and there is no transfer: out_valid←0 at the next edge. out_data and out_chan hold their last values.
- ptr update: on a transfer with rr_en=1, ptr←(g+1) mod CHANNELS, so CHANNELS-1 wraps to 0. With rr_en=0, ptr holds.
- Mode or sel changes take effect at the next grant evaluation. Data already in the output register is unaffected.
- The block never drops or duplicates a word. Each input handshake produces exactly one output handshake, in order.

## Timing
- Latency: 1 cycle from input transfer to out_valid=1.
- Throughput: one word per cycle while out_ready=1 and some channel is valid.
- Backpressure: with out_valid=1 and out_ready=0, all in_ready bits are 0 and the output register holds stable.
- Combinational path: out_ready→in_ready. Consumers must not make out_ready depend on in_ready.
- Reset asserted mid-operation clears state immediately, without waiting for clk, and discards any held word. The first grant possible is the first rising edge after rst_n rises.
- Round-robin fairness: with all CHANNELS valid continuously and out_ready=1, each channel is granted exactly once in every CHANNELS consecutive transfers.

## Test plan
- Reset: rst_n=0 with all inputs valid → out_valid=0, out_data=0, out_chan=0, in_ready=0. After release and one cycle with rr_en=1: out_chan=0, out_data=in_data[0].
- Fixed select, CHANNELS=8, WIDTH=16: sel=5, in_valid=8'hFF, channel 5 data 16'hBEEF, out_ready=1 → in_ready=8'h20. Next cycle out_data=16'hBEEF, out_chan=5. Then set sel=5 with in_valid[5]=0 → no transfer, and out_valid falls after the drain.
- Round-robin: all 8 channels valid, out_ready=1, for 16 cycles → out_chan sequence 0,1,…,7,0,…,7. Then set in_valid=8'b1000_0100 with ptr=3 → next grant is 7, then 2.
- Backpressure: hold out_ready=0 for 4 cycles with data queued → out_data is stable, in_ready=0, ptr is unchanged. Raise out_ready → the held word is consumed and a new word loads in the same cycle, with no gap.
- Non-power-of-2, CHANNELS=5: sel=6 → no grant ever. With rr_en=1 and only channel 4 valid → ptr wraps to 0 after the grant.
- Async reset mid-stream: assert rst_n low between edges while out_valid=1 → out_valid=0 before the next edge, and the held word is lost.

Source files
------------

// File: rtl/arb_mux_n_if.sv
// Handshake bundle for arb_mux_n: N valid/ready input channels, grant controls,
// and one registered valid/ready output.
interface arb_mux_n_if #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 8
);
  localparam int unsigned SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SEL_W-1:0]          sel;
  logic                      rr_en;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, sel, rr_en, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, rr_en, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/arb_mux_n.sv
// Registered N-channel mux with valid/ready on every port; grants either the
// channel named by sel or, in round-robin mode, the first valid channel from ptr.
module arb_mux_n #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 8
) (
  input logic        clk,
  input logic        rst_n,
  arb_mux_n_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [SEL_W-1:0]    chan_q, chan_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic                valid_q, valid_d;
  logic [SEL_W-1:0]    grant;
  logic                grant_vld;
  logic                load_en;
  logic                xfer;
  logic [CHANNELS-1:0] in_ready;

  always_comb begin : grant_sel
    int unsigned idx;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    if (bus.rr_en) begin
      // Rotating scan starting at ptr; first valid channel wins.
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        idx = 32'(ptr_q) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (!grant_vld && bus.in_valid[idx]) begin
          grant_vld = 1'b1;
          grant     = SEL_W'(idx);
        end
      end
    end else if (32'(bus.sel) < CHANNELS) begin
      grant     = bus.sel;
      grant_vld = bus.in_valid[bus.sel];
    end
  end

  assign load_en = !valid_q || bus.out_ready;
  // rst_n gates the handshake so no word is accepted while held in reset.
  assign xfer    = rst_n && grant_vld && load_en;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant] = 1'b1;
  end

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      data_d  = bus.in_data[32'(grant)*WIDTH +: WIDTH];
      chan_d  = grant;
      valid_d = 1'b1;
      if (bus.rr_en) ptr_d = (grant == LAST_CHAN) ? '0 : grant + 1'b1;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: an 8x16 and a 5x8 instance checked each cycle against a
// grant-rule reference model, with directed scenarios followed by random traffic.
module tb_arb_mux_n;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  arb_mux_n_if #(.WIDTH(16), .CHANNELS(8)) bus8 ();
  arb_mux_n_if #(.WIDTH(8), .CHANNELS(5))  bus5 ();

  arb_mux_n #(.WIDTH(16), .CHANNELS(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  arb_mux_n #(.WIDTH(8), .CHANNELS(5))  u_dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  logic [7:0][15:0] d8;
  logic [7:0]       v8;
  logic [2:0]       sel8;
  logic             rr8, ord8;
  logic [4:0][7:0]  d5;
  logic [4:0]       v5;
  logic [2:0]       sel5;
  logic             rr5, ord5;

  assign bus8.in_data   = d8;
  assign bus8.in_valid  = v8;
  assign bus8.sel       = sel8;
  assign bus8.rr_en     = rr8;
  assign bus8.out_ready = ord8;
  assign bus5.in_data   = d5;
  assign bus5.in_valid  = v5;
  assign bus5.sel       = sel5;
  assign bus5.rr_en     = rr5;
  assign bus5.out_ready = ord5;

  // Reference state per instance: [0] = 8 channels, [1] = 5 channels.
  logic [31:0] m_valid [2];
  logic [31:0] m_data  [2];
  logic [31:0] m_chan  [2];
  int          m_ptr   [2];

  function automatic int ref_grant(input logic [7:0] v, input int s, input bit rr,
                                   input int p, input int n);
    if (!rr) return (s < n && v[s] === 1'b1) ? s : -1;
    for (int k = 0; k < n; k++) if (v[(p + k) % n] === 1'b1) return (p + k) % n;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_valid[u] = 0;
      m_data[u]  = 0;
      m_chan[u]  = 0;
      m_ptr[u]   = 0;
    end
  endtask

  task automatic check_outputs();
    chk("dut8_out_valid", 32'(bus8.out_valid), m_valid[0]);
    chk("dut8_out_data",  32'(bus8.out_data),  m_data[0]);
    chk("dut8_out_chan",  32'(bus8.out_chan),  m_chan[0]);
    chk("dut5_out_valid", 32'(bus5.out_valid), m_valid[1]);
    chk("dut5_out_data",  32'(bus5.out_data),  m_data[1]);
    chk("dut5_out_chan",  32'(bus5.out_chan),  m_chan[1]);
  endtask

  // One clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic step();
    logic [7:0]  v [2];
    int          s [2];
    bit          rr [2];
    bit          ordy [2];
    int          n [2];
    logic [31:0] dat [2][8];
    int          g [2];
    bit          ld [2];
    logic [31:0] exp_rdy;
    #1;
    n[0] = 8; n[1] = 5;
    v[0] = v8; v[1] = {3'b0, v5};
    s[0] = int'(sel8); s[1] = int'(sel5);
    rr[0] = rr8; rr[1] = rr5;
    ordy[0] = ord8; ordy[1] = ord5;
    for (int i = 0; i < 8; i++) begin
      dat[0][i] = 32'(d8[i]);
      dat[1][i] = 0;
    end
    for (int i = 0; i < 5; i++) dat[1][i] = 32'(d5[i]);
    for (int u = 0; u < 2; u++) begin
      g[u]    = rst_n ? ref_grant(v[u], s[u], rr[u], m_ptr[u], n[u]) : -1;
      ld[u]   = (m_valid[u] == 0) || ordy[u];
      exp_rdy = (g[u] >= 0 && ld[u]) ? (32'd1 << g[u]) : 32'd0;
      if (u == 0) chk("dut8_in_ready", 32'(bus8.in_ready), exp_rdy);
      else        chk("dut5_in_ready", 32'(bus5.in_ready), exp_rdy);
    end
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        m_valid[u] = 0; m_data[u] = 0; m_chan[u] = 0; m_ptr[u] = 0;
      end else if (g[u] >= 0 && ld[u]) begin
        m_valid[u] = 1;
        m_data[u]  = dat[u][g[u]];
        m_chan[u]  = 32'(g[u]);
        if (rr[u]) m_ptr[u] = (g[u] + 1) % n[u];
      end else if (ordy[u]) begin
        m_valid[u] = 0;
      end
    end
    #2;
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) d8[i] = 16'($urandom);
    for (int i = 0; i < 5; i++) d5[i] = 8'($urandom);
    v8 = 8'hFF; sel8 = 3'd0; rr8 = 1'b1; ord8 = 1'b1;
    v5 = 5'h00; sel5 = 3'd0; rr5 = 1'b0; ord5 = 1'b1;
    model_reset();

    // Reset holds everything idle even with all inputs valid.
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_first_chan", 32'(bus8.out_chan), 32'd0);
    chk("rst_first_data", 32'(bus8.out_data), 32'(d8[0]));

    // Fixed select on channel 5.
    rr8 = 1'b0; sel8 = 3'd5; d8[5] = 16'hBEEF;
    #1;
    chk("fixed_in_ready", 32'(bus8.in_ready), 32'h20);
    step();
    chk("fixed_data", 32'(bus8.out_data), 32'hBEEF);
    chk("fixed_chan", 32'(bus8.out_chan), 32'd5);
    v8 = 8'hDF;
    step();
    chk("fixed_drain", 32'(bus8.out_valid), 32'd0);
    step();

    // Park ptr at 0 (grant 7), then a full fairness sweep.
    rr8 = 1'b1; v8 = 8'h80;
    step();
    v8 = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 8; c++) d8[c] = 16'($urandom);
      step();
      chk("rr_seq", 32'(bus8.out_chan), 32'(i % 8));
    end

    // ptr -> 3 via a grant on 2, then sparse valids grant 7 then wrap to 2.
    v8 = 8'h04;
    step();
    v8 = 8'b1000_0100;
    step();
    chk("rr_sparse_first", 32'(bus8.out_chan), 32'd7);
    step();
    chk("rr_sparse_second", 32'(bus8.out_chan), 32'd2);

    // Backpressure: held word stable, then drain and refill without a gap.
    v8 = 8'hFF; ord8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 8; c++) d8[c] = 16'($urandom);
      step();
      chk("bp_hold_chan", 32'(bus8.out_chan), 32'd2);
    end
    ord8 = 1'b1;
    step();
    chk("bp_refill_valid", 32'(bus8.out_valid), 32'd1);
    chk("bp_refill_chan", 32'(bus8.out_chan), 32'd3);

    // 5-channel instance: out-of-range sel never grants; ptr wraps after channel 4.
    v5 = 5'h1F; sel5 = 3'd6; rr5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sel_oob_ready", 32'(bus5.in_ready), 32'd0);
    end
    rr5 = 1'b1; v5 = 5'b10000;
    step();
    chk("wrap_grant4", 32'(bus5.out_chan), 32'd4);
    v5 = 5'b10001;
    step();
    chk("wrap_grant0", 32'(bus5.out_chan), 32'd0);

    // Random traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < 8; c++) d8[c] = 16'($urandom);
      for (int c = 0; c < 5; c++) d5[c] = 8'($urandom);
      v8 = 8'($urandom); sel8 = 3'($urandom_range(0, 7)); rr8 = 1'($urandom_range(0, 1));
      ord8 = ($urandom_range(0, 3) != 0);
      v5 = 5'($urandom); sel5 = 3'($urandom_range(0, 7)); rr5 = 1'($urandom_range(0, 1));
      ord5 = ($urandom_range(0, 3) != 0);
      step();
    end

    // Asynchronous reset between edges discards the held word immediately.
    v8 = 8'hFF; rr8 = 1'b1; ord8 = 1'b1;
    v5 = 5'h1F; rr5 = 1'b1; ord5 = 1'b1;
    step();
    ord8 = 1'b0; ord5 = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_ready8", 32'(bus8.in_ready), 32'd0);
    chk("async_rst_ready5", 32'(bus5.in_ready), 32'd0);
    check_outputs();
    step();
    rst_n = 1'b1;
    ord8 = 1'b1; ord5 = 1'b1;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
